// File: rtl/fir_coeff_loader_pkg.sv
// Shared definitions for the fir_* blocks: default sizes and loader FSM encoding.
package fir_coeff_loader_pkg;

    localparam int unsigned FIR_N_DEFAULT       = 4;
    localparam int unsigned FIR_COEFF_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PENDING = 2'd2
    } ld_state_e;

endpackage : fir_coeff_loader_pkg

// File: rtl/fir_coeff_loader.sv
// Coefficient loader: collects N signed beats into a shadow bank and swaps the
// whole set into the active register only on a sample-boundary commit strobe.
module fir_coeff_loader
    import fir_coeff_loader_pkg::*;
#(
    parameter int unsigned N           = FIR_N_DEFAULT,
    parameter int unsigned COEFF_WIDTH = FIR_COEFF_W_DEFAULT,
    parameter logic [N*COEFF_WIDTH-1:0] INIT_COEFFS = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [COEFF_WIDTH-1:0]     coeff_in,
    input  logic                       coeff_valid,
    input  logic                       coeff_last,
    output logic                       coeff_ready,
    input  logic                       commit_en,
    output logic [N*COEFF_WIDTH-1:0]   packed_coeffs,
    output logic                       loaded,
    output logic                       error,
    output logic                       busy
);

    localparam int unsigned IDX_W = (N > 2) ? $clog2(N) : 1;
    localparam int unsigned PW    = N * COEFF_WIDTH;

    ld_state_e              state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [COEFF_WIDTH-1:0] shadow_q [N];
    logic [COEFF_WIDTH-1:0] shadow_d [N];
    logic [PW-1:0]          packed_q, packed_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   loaded_q, loaded_d;
    logic                   error_q, error_d;
    logic                   accept_c;
    logic                   at_end_c;

    // Next-state, shadow writes, commit and pulse generation.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        packed_d = packed_q;
        loaded_d = 1'b0;
        error_d  = 1'b0;
        accept_c = coeff_valid && ready_q;
        at_end_c = (idx_q == IDX_W'(N - 1));

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (coeff_last) begin
                        // Single-beat set is always short.
                        error_d = 1'b1;
                        for (int unsigned k = 0; k < N; k++) shadow_d[k] = '0;
                    end else begin
                        shadow_d[0] = coeff_in;
                        idx_d       = IDX_W'(1);
                        state_d     = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept_c) begin
                    if (at_end_c && coeff_last) begin
                        shadow_d[idx_q] = coeff_in;
                        state_d         = ST_PENDING;
                    end else if (at_end_c || coeff_last) begin
                        // Short or long set: drop everything collected so far.
                        error_d = 1'b1;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                        for (int unsigned k = 0; k < N; k++) shadow_d[k] = '0;
                    end else begin
                        shadow_d[idx_q] = coeff_in;
                        idx_d           = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PENDING: begin
                if (commit_en) begin
                    for (int unsigned k = 0; k < N; k++)
                        packed_d[k*COEFF_WIDTH +: COEFF_WIDTH] = shadow_q[k];
                    loaded_d = 1'b1;
                    idx_d    = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d != ST_PENDING);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, shadow bank, active set and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            for (int unsigned k = 0; k < N; k++) shadow_q[k] <= '0;
            packed_q <= INIT_COEFFS;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            loaded_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            packed_q <= packed_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            loaded_q <= loaded_d;
            error_q  <= error_d;
        end
    end

    assign coeff_ready   = ready_q;
    assign busy          = busy_q;
    assign loaded        = loaded_q;
    assign error         = error_q;
    assign packed_coeffs = packed_q;

endmodule : fir_coeff_loader

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: directed scenarios plus random traffic against a
// queue-based set model.
module tb_fir_coeff_loader;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned PW = N * W;
    localparam logic [PW-1:0] INIT = 32'hA55A_3CC3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  coeff_in;
    logic          coeff_valid;
    logic          coeff_last;
    logic          coeff_ready;
    logic          commit_en;
    logic [PW-1:0] packed_coeffs;
    logic          loaded;
    logic          error;
    logic          busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: beats of the set being gathered, a completed set
    // waiting for commit, and expected observable outputs.
    logic [W-1:0]  set_q[$];
    logic          have_set;
    logic [PW-1:0] exp_packed;
    logic          exp_ready;
    logic          exp_loaded;
    logic          exp_error;

    always #5 clk = ~clk;

    fir_coeff_loader #(
        .N(N), .COEFF_WIDTH(W), .INIT_COEFFS(INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .coeff_in(coeff_in), .coeff_valid(coeff_valid), .coeff_last(coeff_last),
        .coeff_ready(coeff_ready), .commit_en(commit_en),
        .packed_coeffs(packed_coeffs), .loaded(loaded), .error(error), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] pack_set();
        logic [PW-1:0] p = '0;
        for (int k = 0; k < int'(N); k++) p[k*W +: W] = set_q[k];
        return p;
    endfunction

    task automatic check_outputs(input string ctx);
        chk({ctx, ".ready"},  64'(coeff_ready),   64'(exp_ready));
        chk({ctx, ".busy"},   64'(busy),          64'(have_set || (set_q.size() != 0)));
        chk({ctx, ".loaded"}, 64'(loaded),        64'(exp_loaded));
        chk({ctx, ".error"},  64'(error),         64'(exp_error));
        chk({ctx, ".packed"}, 64'(packed_coeffs), 64'(exp_packed));
    endtask

    // One clock: drive inputs, advance the model, then check after the edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic l,
                        input logic c, input string ctx);
        @(negedge clk);
        coeff_valid = v; coeff_in = d; coeff_last = l; commit_en = c;
        exp_loaded = 1'b0;
        exp_error  = 1'b0;
        if (have_set) begin
            if (c) begin
                exp_packed = pack_set();
                exp_loaded = 1'b1;
                have_set   = 1'b0;
                set_q.delete();
            end
        end else if (v && exp_ready) begin
            set_q.push_back(d);
            if (l && set_q.size() == N) begin
                have_set = 1'b1;
            end else if (l || set_q.size() == N) begin
                exp_error = 1'b1;
                set_q.delete();
            end
        end
        exp_ready = !have_set;
        @(posedge clk);
        #1;
        check_outputs(ctx);
    endtask

    task automatic idle(input int cycles, input string ctx);
        for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b0, 1'b0, ctx);
    endtask

    task automatic send_set(input logic [W-1:0] b0, input logic [W-1:0] b1,
                            input logic [W-1:0] b2, input logic [W-1:0] b3,
                            input logic last_on_end, input logic commit_on_end,
                            input string ctx);
        step(1'b1, b0, 1'b0, 1'b0, ctx);
        step(1'b1, b1, 1'b0, 1'b0, ctx);
        step(1'b1, b2, 1'b0, 1'b0, ctx);
        step(1'b1, b3, last_on_end, commit_on_end, ctx);
    endtask

    task automatic apply_reset(input string ctx);
        @(negedge clk);
        rst_n = 1'b0;
        coeff_valid = 1'b0; coeff_last = 1'b0; commit_en = 1'b0;
        set_q.delete();
        have_set   = 1'b0;
        exp_packed = INIT;
        exp_ready  = 1'b0;
        exp_loaded = 1'b0;
        exp_error  = 1'b0;
        #1;
        check_outputs({ctx, ".async"});
        @(posedge clk);
        #1;
        check_outputs({ctx, ".held"});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        coeff_in = '0; coeff_valid = 1'b0; coeff_last = 1'b0; commit_en = 1'b0;
        set_q.delete();
        have_set = 1'b0; exp_packed = INIT; exp_ready = 1'b0;
        exp_loaded = 1'b0; exp_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic set and delayed commit.
        idle(1, "ready_rise");
        send_set(8'hFE, 8'hFF, 8'h03, 8'h04, 1'b1, 1'b0, "basic");
        idle(2, "basic_wait");
        step(1'b0, '0, 1'b0, 1'b1, "basic_commit");
        chk("basic_value", 64'(packed_coeffs), 64'h0403_FFFE);
        idle(2, "basic_after");

        // Short set.
        step(1'b1, 8'd5, 1'b0, 1'b0, "short");
        step(1'b1, 8'd6, 1'b1, 1'b0, "short_end");
        chk("short_err", 64'(error), 64'd1);
        idle(2, "short_after");

        // Long set followed by a good set.
        send_set(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, "long");
        chk("long_err", 64'(error), 64'd1);
        send_set(8'h81, 8'h7F, 8'h00, 8'hC0, 1'b1, 1'b0, "long_next");
        step(1'b0, '0, 1'b0, 1'b1, "long_commit");
        chk("long_value", 64'(packed_coeffs), 64'hC000_7F81);

        // Back-pressure while pending.
        send_set(8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b0, "bp");
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, "bp_hold");
        step(1'b1, 8'h99, 1'b0, 1'b1, "bp_commit");
        chk("bp_value", 64'(packed_coeffs), 64'h0403_0201);
        step(1'b0, '0, 1'b0, 1'b0, "bp_ready");

        // Reset mid-load, then a fresh set lands at slice 0.
        step(1'b1, 8'hAA, 1'b0, 1'b0, "rst_mid");
        step(1'b1, 8'hBB, 1'b0, 1'b0, "rst_mid");
        apply_reset("rst_mid");
        idle(1, "rst_ready");
        send_set(8'h10, 8'h20, 8'h30, 8'h40, 1'b1, 1'b0, "rst_next");
        step(1'b0, '0, 1'b0, 1'b1, "rst_next_commit");
        chk("rst_next_value", 64'(packed_coeffs), 64'h4030_2010);

        // Commit strobe on the final beat is ignored; next cycle commits.
        send_set(8'h5A, 8'hA5, 8'h0F, 8'hF0, 1'b1, 1'b1, "coinc");
        chk("coinc_nocommit", 64'(loaded), 64'd0);
        step(1'b0, '0, 1'b0, 1'b1, "coinc_commit");
        chk("coinc_value", 64'(packed_coeffs), 64'hF00F_A55A);

        // Random traffic, including reset inside pending.
        for (int i = 0; i < 600; i++) begin
            logic v, l, c;
            v = ($urandom_range(0, 3) != 0);
            if (set_q.size() == N - 1) l = ($urandom_range(0, 7) != 0);
            else                       l = ($urandom_range(0, 11) == 0);
            c = ($urandom_range(0, 3) == 0);
            step(v, 8'($urandom), l, c, "rand");
            if (i == 300) apply_reset("rand_rst");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fir_coeff_loader
